// File: rtl/pleasure_level.sv
// Saturating pleasure-level integrator with prescaled update tick, idle decay toward a
// baseline, and a hysteretic mood classifier.
module pleasure_level #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BASELINE  = 128,
    parameter int unsigned TICK_DIV  = 16,
    parameter int unsigned DECAY_DIV = 8,
    parameter int unsigned STEP      = 1,
    parameter int unsigned HI_TH     = 192,
    parameter int unsigned LO_TH     = 64,
    parameter int unsigned HYST      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             pleasure_inc,
    input  logic             pleasure_dec,
    output logic [WIDTH-1:0] level,
    output logic [1:0]       mood,
    output logic             changed
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam int unsigned IW = $clog2(DECAY_DIV + 1);

    localparam logic [WIDTH:0]   MAX_LEVEL    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   STEP_W       = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] BASE         = WIDTH'(BASELINE);
    localparam logic [WIDTH-1:0] HAPPY_ENTER  = WIDTH'(HI_TH);
    localparam logic [WIDTH-1:0] HAPPY_EXIT   = WIDTH'(HI_TH - HYST);
    localparam logic [WIDTH-1:0] UNHAPPY_ENTER = WIDTH'(LO_TH);
    localparam logic [WIDTH-1:0] UNHAPPY_EXIT = WIDTH'(LO_TH + HYST);

    typedef enum logic [1:0] {
        MoodNeutral = 2'b00,
        MoodHappy   = 2'b01,
        MoodUnhappy = 2'b10
    } mood_e;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idle_q, idle_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic             pend_inc_q, pend_inc_d;
    logic             pend_dec_q, pend_dec_d;
    logic             changed_q, changed_d;
    mood_e            mood_q, mood_d;

    logic             tick;
    logic             want_inc, want_dec;
    logic [WIDTH:0]   wide_up, wide_down;

    assign tick     = ena && (cnt_q == CW'(TICK_DIV - 1));
    assign want_inc = pend_inc_q || pleasure_inc;
    assign want_dec = pend_dec_q || pleasure_dec;
    assign wide_up   = {1'b0, level_q} + STEP_W;
    // A borrow out of the extra bit marks an underflow below zero.
    assign wide_down = {1'b0, level_q} - STEP_W;

    always_comb begin
        cnt_d      = cnt_q;
        idle_d     = idle_q;
        level_d    = level_q;
        pend_inc_d = pend_inc_q || pleasure_inc;
        pend_dec_d = pend_dec_q || pleasure_dec;

        if (ena) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end

        if (tick) begin
            pend_inc_d = 1'b0;
            pend_dec_d = 1'b0;
            if (want_inc && !want_dec) begin
                level_d = (wide_up > MAX_LEVEL) ? '1 : wide_up[WIDTH-1:0];
                idle_d  = '0;
            end else if (want_dec && !want_inc) begin
                level_d = wide_down[WIDTH] ? '0 : wide_down[WIDTH-1:0];
                idle_d  = '0;
            end else if (idle_q == IW'(DECAY_DIV - 1)) begin
                idle_d = '0;
                if (level_q < BASE) begin
                    level_d = level_q + WIDTH'(1);
                end else if (level_q > BASE) begin
                    level_d = level_q - WIDTH'(1);
                end
            end else begin
                idle_d = idle_q + IW'(1);
            end
        end

        changed_d = tick && (level_d != level_q);
    end

    // Mood is judged from the registered level, so it trails level by one cycle.
    always_comb begin
        mood_d = mood_q;
        unique case (mood_q)
            MoodNeutral: begin
                if (level_q >= HAPPY_ENTER) begin
                    mood_d = MoodHappy;
                end else if (level_q <= UNHAPPY_ENTER) begin
                    mood_d = MoodUnhappy;
                end
            end
            MoodHappy: begin
                if (level_q < HAPPY_EXIT) begin
                    mood_d = MoodNeutral;
                end
            end
            MoodUnhappy: begin
                if (level_q > UNHAPPY_EXIT) begin
                    mood_d = MoodNeutral;
                end
            end
            default: mood_d = MoodNeutral;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idle_q     <= '0;
            level_q    <= BASE;
            pend_inc_q <= 1'b0;
            pend_dec_q <= 1'b0;
            changed_q  <= 1'b0;
            mood_q     <= MoodNeutral;
        end else begin
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            level_q    <= level_d;
            pend_inc_q <= pend_inc_d;
            pend_dec_q <= pend_dec_d;
            changed_q  <= changed_d;
            mood_q     <= mood_d;
        end
    end

    assign level   = level_q;
    assign mood    = mood_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_pleasure_level.sv
// Bench for pleasure_level: integer reference model compared every cycle, plus directed
// literal expectations that pin the model at the interesting points.
module tb_pleasure_level;

    localparam int LVL_MAX  = 255;
    localparam int BASE     = 128;
    localparam int TDIV     = 16;
    localparam int DDIV     = 8;
    localparam int HI_ENTER = 192;
    localparam int HI_EXIT  = 184;
    localparam int LO_ENTER = 64;
    localparam int LO_EXIT  = 72;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena   = 1'b0;
    logic       inc   = 1'b0;
    logic       dec   = 1'b0;
    logic [7:0] level;
    logic [1:0] mood;
    logic       changed;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pleasure_level dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .pleasure_inc (inc),
        .pleasure_dec (dec),
        .level        (level),
        .mood         (mood),
        .changed      (changed)
    );

    // Reference model: plain integer bookkeeping of enabled cycles, requests and idle ticks.
    int m_cnt, m_idle, m_level, m_mood;
    bit m_pi, m_pd, m_changed;

    always @(posedge clk or negedge rst_n) begin
        bit tk, up, dn;
        int nl, ni, nm;
        if (!rst_n) begin
            m_cnt     <= 0;
            m_idle    <= 0;
            m_level   <= BASE;
            m_mood    <= 0;
            m_changed <= 1'b0;
            m_pi      <= 1'b0;
            m_pd      <= 1'b0;
        end else begin
            tk = ena && (m_cnt == TDIV - 1);
            up = m_pi || inc;
            dn = m_pd || dec;
            nl = m_level;
            ni = m_idle;
            if (tk) begin
                if (up && !dn) begin
                    nl = (m_level + 1 > LVL_MAX) ? LVL_MAX : m_level + 1;
                    ni = 0;
                end else if (dn && !up) begin
                    nl = (m_level - 1 < 0) ? 0 : m_level - 1;
                    ni = 0;
                end else begin
                    ni = m_idle + 1;
                    if (ni == DDIV) begin
                        ni = 0;
                        if (nl < BASE) nl = nl + 1;
                        else if (nl > BASE) nl = nl - 1;
                    end
                end
            end
            nm = m_mood;
            if (m_mood == 0) begin
                if (m_level >= HI_ENTER) nm = 1;
                else if (m_level <= LO_ENTER) nm = 2;
            end else if (m_mood == 1) begin
                if (m_level < HI_EXIT) nm = 0;
            end else begin
                if (m_level > LO_EXIT) nm = 0;
            end
            m_cnt     <= ena ? (m_cnt + 1) % TDIV : m_cnt;
            m_idle    <= ni;
            m_level   <= nl;
            m_mood    <= nm;
            m_changed <= tk && (nl != m_level);
            m_pi      <= tk ? 1'b0 : (m_pi || inc);
            m_pd      <= tk ? 1'b0 : (m_pd || dec);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n cycles; on each falling edge compare the DUT against the model.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rst_n) begin
                check("model_level", int'(level), m_level);
                check("model_mood", int'(mood), m_mood);
                check("model_changed", int'(changed), int'(m_changed));
            end
        end
    endtask

    task automatic wait_level(input int target, input int budget, input string name);
        int k = 0;
        while (int'(level) != target && k < budget) begin
            step(1);
            k++;
        end
        check(name, int'(level), target);
    endtask

    task automatic quiet(input int n, input string name);
        int pulses = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (changed) pulses++;
        end
        check(name, pulses, 0);
    endtask

    initial begin
        ena = 1'b1;
        inc = 1'b1;
        step(3);
        rst_n = 1'b1;

        // Reset mid-count with a request active, then time the first tick.
        step(5);
        #2 rst_n = 1'b0;
        #1;
        check("t1_rst_level", int'(level), 128);
        check("t1_rst_mood", int'(mood), 0);
        check("t1_rst_changed", int'(changed), 0);
        step(1);
        rst_n = 1'b1;
        step(15);
        check("t1_before_tick", int'(level), 128);
        step(1);
        check("t1_first_tick", int'(level), 129);
        check("t1_changed", int'(changed), 1);
        inc = 1'b0;
        step(1);
        check("t1_changed_drop", int'(changed), 0);

        // Single one-cycle request at prescaler count 3.
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);
        inc = 1'b1;
        step(1);
        inc = 1'b0;
        step(12);
        check("t2_level", int'(level), 129);
        check("t2_changed", int'(changed), 1);
        step(1);
        check("t2_changed_drop", int'(changed), 0);
        step(111);
        check("t2_idle7", int'(level), 129);
        step(16);
        check("t2_decay", int'(level), 128);

        // Ramp into HAPPY, then back down through the hysteresis band.
        inc = 1'b1;
        wait_level(192, 1100, "t3_reach_192");
        check("t3_mood_lag", int'(mood), 0);
        step(1);
        check("t3_happy", int'(mood), 1);
        inc = 1'b0;
        dec = 1'b1;
        wait_level(184, 200, "t3_reach_184");
        step(1);
        check("t3_hold_184", int'(mood), 1);
        wait_level(183, 200, "t3_reach_183");
        check("t3_hold_lag", int'(mood), 1);
        step(1);
        check("t3_exit", int'(mood), 0);

        // Saturation at both ends.
        dec = 1'b0;
        inc = 1'b1;
        wait_level(255, 1200, "t4_reach_255");
        quiet(48, "t4_sat_hi_pulses");
        check("t4_sat_hi", int'(level), 255);
        inc = 1'b0;
        dec = 1'b1;
        wait_level(0, 4200, "t4_reach_0");
        quiet(48, "t4_sat_lo_pulses");
        check("t4_sat_lo", int'(level), 0);
        check("t4_unhappy", int'(mood), 2);

        // Conflicting requests count as idle and decay toward baseline.
        dec = 1'b0;
        inc = 1'b1;
        wait_level(130, 2200, "t5_reach_130");
        dec = 1'b1;
        step(128);
        check("t5_decay1", int'(level), 129);
        step(128);
        check("t5_decay2", int'(level), 128);
        quiet(160, "t5_hold_pulses");
        check("t5_hold", int'(level), 128);

        // Enable gating: requests captured while frozen are applied on the next tick.
        dec = 1'b0;
        ena = 1'b0;
        inc = 1'b1;
        quiet(100, "t6_frozen_pulses");
        check("t6_frozen", int'(level), 128);
        inc = 1'b0;
        ena = 1'b1;
        step(15);
        check("t6_before_tick", int'(level), 128);
        step(1);
        check("t6_pending", int'(level), 129);
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
